// File: rtl/ecc_host_seq_if.sv
// ecc_host_seq_if: command channel between the host sequencer and the control block
interface ecc_host_seq_if;
  logic [3:0]   start_o;
  logic [255:0] data_o;
  logic [255:0] export_key;
  logic         Done;
  modport master (output start_o, data_o, input export_key, Done);
  modport slave (input start_o, data_o, output export_key, Done);
endinterface

// File: rtl/ecc_host_seq.sv
// ecc_host_seq: loads message/seed into control, steps every command code and captures each result
module ecc_host_seq #(
  parameter int          SETTLE  = 2,
  parameter logic [31:0] TIMEOUT = 32'd16777216
) (
  input  logic                  Clk,
  input  logic                  reset,
  ecc_host_seq_if.master        ctl,
  input  logic                  go,
  input  logic [255:0]          msg_i,
  input  logic [255:0]          seed_i,
  input  logic [3:0]            rd_addr,
  output logic [255:0]          rd_data,
  output logic                  busy,
  output logic                  finished,
  output logic                  err,
  output logic [3:0]            step
);
  typedef enum logic [3:0] {
    IDLE, CMD1, LDMSG, CMD2, LDSEED, CMD3, SETL, WAIT, STEP, FSET, FWAIT, DONE, RST15, ERR
  } state_t;
  state_t        state_q, state_d;
  logic [255:0]  msg_q, msg_d, seed_q, seed_d;
  logic [255:0]  res_q [10];
  logic [255:0]  res_d [10];
  logic [3:0]    step_q, step_d;
  logic [31:0]   wait_q, wait_d;
  logic [7:0]    set_q, set_d;
  logic          fin_q, fin_d;
  logic          accept, settled;
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    seed_d  = seed_q;
    res_d   = res_q;
    step_d  = step_q;
    fin_d   = fin_q;
    set_d   = 8'd0;
    wait_d  = 32'd0;
    accept  = go && (state_q == IDLE || state_q == DONE);
    settled = set_q == 8'(SETTLE - 1);
    if (accept) begin
      msg_d   = msg_i;
      seed_d  = seed_i;
      step_d  = 4'd0;
      fin_d   = 1'b0;
      for (int i = 0; i < 10; i++) res_d[i] = '0;
      state_d = state_q == IDLE ? CMD1 : RST15;
    end
    case (state_q)
      CMD1:   state_d = LDMSG;
      LDMSG:  state_d = CMD2;
      CMD2:   state_d = LDSEED;
      LDSEED: state_d = CMD3;
      CMD3:   state_d = SETL;
      RST15:  state_d = CMD1;
      SETL, FSET: begin
        set_d = set_q + 8'd1;
        if (settled) state_d = state_q == SETL ? WAIT : FWAIT;
      end
      WAIT, FWAIT: begin
        if (ctl.Done) begin
          if (state_q == WAIT) res_d[step_q] = ctl.export_key;
          fin_d   = state_q == FWAIT;
          state_d = state_q == WAIT ? STEP : DONE;
        end else begin
          wait_d = wait_q + 32'd1;
          if (wait_d == TIMEOUT) state_d = ERR;
        end
      end
      STEP: begin
        step_d  = step_q == 4'd9 ? step_q : step_q + 4'd1;
        state_d = step_q == 4'd9 ? FSET : SETL;
      end
      default: ;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      seed_q  <= '0;
      step_q  <= 4'd0;
      wait_q  <= 32'd0;
      set_q   <= 8'd0;
      fin_q   <= 1'b0;
      for (int i = 0; i < 10; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      seed_q  <= seed_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      set_q   <= set_d;
      fin_q   <= fin_d;
      res_q   <= res_d;
    end
  end
  always_comb begin
    ctl.start_o = state_q == CMD1  ? 4'd1 :
                  state_q == CMD2  ? 4'd2 :
                  state_q == CMD3  ? 4'd3 :
                  state_q == STEP  ? 4'd4 + step_q :
                  state_q == RST15 ? 4'd15 : 4'd0;
    ctl.data_o  = (state_q == CMD1 || state_q == LDMSG || state_q == CMD2) ? msg_q :
                  (state_q == LDSEED || state_q == CMD3) ? seed_q : '0;
    rd_data     = rd_addr < 4'd10 ? res_q[rd_addr] : '0;
    busy        = !(state_q == IDLE || state_q == DONE || state_q == ERR);
    err         = state_q == ERR;
    finished    = fin_q;
    step        = step_q;
  end
endmodule

// File: tb/tb_ecc_host_seq.sv
// tb_ecc_host_seq: scoreboard bench driving ecc_host_seq against a behavioural control model
module tb_ecc_host_seq;
  logic         Clk = 0, reset = 1, go = 0;
  logic [255:0] msg_i = '0, seed_i = '0, rd_data;
  logic [3:0]   rd_addr = 4'd0, step;
  logic         busy, finished, err;
  int           checks = 0, passed = 0, cyc = 0;

  ecc_host_seq_if ctl();
  ecc_host_seq #(.SETTLE(2), .TIMEOUT(32'd64)) dut (
    .Clk(Clk), .reset(reset), .ctl(ctl.master), .go(go), .msg_i(msg_i), .seed_i(seed_i),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .finished(finished), .err(err), .step(step));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // control model: step results appear a fixed delay after each step command
  logic [255:0] keys [11];
  int           dly = 5, hang_ph = -1, ph = 0, bcnt = 0;
  logic         active = 0;
  logic [3:0]   prev = 0;
  logic [255:0] bmsg = '0, bseed = '0, junk;
  always @(posedge Clk) begin
    if (reset) begin
      ctl.Done <= 1'b0; ctl.export_key <= '0; active <= 1'b0; bcnt <= 0; prev <= 4'd0; ph <= 0;
    end else begin
      prev <= ctl.start_o;
      if (prev == 4'd1) bmsg <= ctl.data_o;
      if (prev == 4'd2) bseed <= ctl.data_o;
      if (ctl.start_o >= 4'd3 && ctl.start_o <= 4'd13) begin
        for (int w = 0; w < 8; w++) junk[w*32 +: 32] = $urandom;
        ph <= int'(ctl.start_o) - 3; bcnt <= 0; ctl.Done <= 1'b0; active <= 1'b1;
        ctl.export_key <= junk;
      end else if (ctl.start_o == 4'd15) begin
        active <= 1'b0; ctl.Done <= 1'b0;
      end else if (active && !ctl.Done && ph != hang_ph) begin
        bcnt <= bcnt + 1;
        if (bcnt + 1 == dly) begin ctl.Done <= 1'b1; ctl.export_key <= keys[ph]; end
      end
    end
  end

  typedef struct { logic [3:0] code; logic [255:0] data; int cyc; } cmd_t;
  cmd_t q[$];
  logic [3:0] last_s = 4'd0;
  int last_cmd_cyc = 0;

  always @(negedge Clk) begin
    cmd_t e;
    if (!reset && ctl.start_o != 4'd0) begin
      last_cmd_cyc = cyc;
      if (last_s != 4'd15) chk("cmd_pulse_gap", 256'(last_s), 256'd0);
      if (q.size() == 0) chk("unexpected_cmd", 256'(ctl.start_o), 256'd0);
      else begin
        e = q.pop_front();
        chk("cmd_code", 256'(ctl.start_o), 256'(e.code));
        chk("cmd_data", ctl.data_o, e.data);
        if (e.cyc >= 0) chk("cmd_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
    last_s = reset ? 4'd0 : ctl.start_o;
  end

  task automatic issue_go(input logic [255:0] m, input logic [255:0] s, input bit acc, input bit fd, input int last);
    int b;
    @(posedge Clk); #1;
    msg_i = m; seed_i = s; go = 1'b1;
    if (acc) begin
      b = cyc + (fd ? 1 : 0);
      if (fd) q.push_back('{4'd15, 256'd0, cyc + 1});
      q.push_back('{4'd1, m, b + 1});
      q.push_back('{4'd2, m, b + 3});
      q.push_back('{4'd3, s, b + 5});
      for (int k = 4; k <= last; k++) q.push_back('{4'(k), 256'd0, -1});
    end
    @(posedge Clk); #1;
    go = 1'b0;
  endtask

  task automatic set_keys(input bit fixed);
    for (int k = 0; k < 11; k++)
      if (fixed) keys[k] = 256'(256 + k);
      else for (int w = 0; w < 8; w++) keys[k][w*32 +: 32] = $urandom;
  endtask

  task automatic check_buf(input int valid_upto);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a); #1;
      chk($sformatf("rd_%0d", a), rd_data, (a < valid_upto) ? keys[a] : 256'd0);
    end
  endtask

  task automatic check_idle();
    chk("idle_start", 256'(ctl.start_o), 256'd0);
    chk("idle_data", ctl.data_o, 256'd0);
    chk("idle_busy", 256'(busy), 256'd0);
    chk("idle_fin", 256'(finished), 256'd0);
    chk("idle_err", 256'(err), 256'd0);
    chk("idle_step", 256'(step), 256'd0);
    check_buf(0);
  endtask

  task automatic run(input logic [255:0] m, input logic [255:0] s, input bit fd, input int d, input bit fixed);
    int i;
    dly = d; hang_ph = -1;
    set_keys(fixed);
    issue_go(m, s, 1'b1, fd, 13);
    if (fd) begin
      chk("rerun_fin_clear", 256'(finished), 256'd0);
      rd_addr = 4'd0; #1;
      chk("rerun_buf_clear", rd_data, 256'd0);
    end
    for (i = 0; i < 3000 && !finished; i++) @(negedge Clk);
    @(negedge Clk);
    chk("run_finished", 256'(finished), 256'd1);
    chk("run_busy", 256'(busy), 256'd0);
    chk("run_queue_empty", 256'(q.size()), 256'd0);
    chk("bfm_msg", bmsg, m);
    chk("bfm_seed", bseed, s);
    check_buf(10);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    int i, err_cyc;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    @(negedge Clk);
    check_idle();

    run({32{8'hA5}}, {32{8'h3C}}, 1'b0, 5, 1'b1);
    run(256'd1, rnd256(), 1'b1, 5, 1'b1);
    run(rnd256(), rnd256(), 1'b1, $urandom_range(1, 20), 1'b0);

    dly = $urandom_range(3, 12); hang_ph = -1;
    set_keys(1'b0);
    issue_go(rnd256(), rnd256(), 1'b1, 1'b1, 13);
    for (i = 0; i < 2000 && step != 4'd3; i++) @(negedge Clk);
    chk("reached_step3", 256'(step), 256'd3);
    issue_go(rnd256(), rnd256(), 1'b0, 1'b0, 0);
    chk("busy_go_ignored_step", 256'(step), 256'd3);
    @(posedge Clk); #1 reset = 1'b1;
    @(posedge Clk); #1 reset = 1'b0;
    q.delete();
    @(negedge Clk);
    check_idle();
    run(rnd256(), rnd256(), 1'b0, $urandom_range(1, 20), 1'b0);

    reset = 1'b1; @(posedge Clk); #1 reset = 1'b0;
    dly = $urandom_range(2, 10); hang_ph = 6;
    set_keys(1'b0);
    issue_go(rnd256(), rnd256(), 1'b1, 1'b0, 9);
    for (i = 0; i < 3000 && !err; i++) @(negedge Clk);
    err_cyc = cyc;
    chk("timeout_err", 256'(err), 256'd1);
    chk("timeout_latency", 256'(err_cyc - last_cmd_cyc), 256'd67);
    chk("timeout_start", 256'(ctl.start_o), 256'd0);
    chk("timeout_busy", 256'(busy), 256'd0);
    chk("timeout_step", 256'(step), 256'd6);
    chk("timeout_queue_empty", 256'(q.size()), 256'd0);
    check_buf(6);
    issue_go(rnd256(), rnd256(), 1'b0, 1'b0, 0);
    repeat (10) @(negedge Clk);
    chk("err_sticky", 256'(err), 256'd1);
    chk("err_go_ignored", 256'(busy), 256'd0);
    reset = 1'b1; @(posedge Clk); #1 reset = 1'b0;
    @(negedge Clk);
    check_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end
endmodule
